// File: rtl/scale_down_2x_2ppc.sv
// rtl/scale_down_2x_2ppc.sv - 2x2 down-scaler for a 2-pixel-per-clock RGB stream
//
// Every 2x2 input block becomes one output pixel. The output stays packed two
// pixels per beat, so one output beat leaves for every two odd-row input beats.
//
// Build option SCALE_DOWN_2X_AVG_EN:
//   defined   - 2x2 box average, rounded half up.
//   undefined - nearest-neighbour decimation (the top-left pixel of each block).
//               Handshake, latency and output cadence are the same as above.
//
// Ports:
//   clk, rst              single clock; synchronous active-high reset
//   in_red/green/blue     two input pixels per beat, [P_DEPTH-1:0] = left pixel
//   in_valid, in_ready    input handshake, a beat is taken when both are high
//   out_red/green/blue    two reduced pixels per beat, [P_DEPTH-1:0] = left pixel
//   out_valid, out_ready  output handshake (strict valid/ready)

module scale_down_2x_2ppc #(
    parameter int P_DEPTH        = 8,
    parameter int IN_FRAME_WIDTH = 540,
    parameter int ADDR_WIDTH     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*P_DEPTH-1:0] in_red,
    input  logic [2*P_DEPTH-1:0] in_green,
    input  logic [2*P_DEPTH-1:0] in_blue,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*P_DEPTH-1:0] out_red,
    output logic [2*P_DEPTH-1:0] out_green,
    output logic [2*P_DEPTH-1:0] out_blue,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PD = P_DEPTH;
`ifdef SCALE_DOWN_2X_AVG_EN
    // Horizontal sums are stored at full precision.
    localparam int LB_CH = P_DEPTH + 1;
`else
    localparam int LB_CH = P_DEPTH;
`endif
    localparam int LB_W = 3 * LB_CH;
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IN_FRAME_WIDTH / 2 - 1);

    logic [ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0] col_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  row_odd;
    logic                  acc;
    logic                  wrap;

    logic [LB_W-1:0] lb_mem [0:(1<<ADDR_WIDTH)-1];
    logic [LB_W-1:0] lb_wdata;
    logic [LB_W-1:0] lb_rdata;

    // Reduced pixel for the current block and the held left pixel, both {b, g, r}.
    logic [3*PD-1:0] p;
    logic [3*PD-1:0] hold;

    assign in_ready = ~out_valid | out_ready;
    assign acc      = in_valid & in_ready;
    assign wrap     = (col == LAST_COL);
    assign col_nxt  = acc ? (wrap ? '0 : col + ADDR_WIDTH'(1)) : col;

`ifdef SCALE_DOWN_2X_AVG_EN
    logic [PD:0] h_red;
    logic [PD:0] h_green;
    logic [PD:0] h_blue;

    assign h_red    = {1'b0, in_red[PD-1:0]}   + {1'b0, in_red[2*PD-1:PD]};
    assign h_green  = {1'b0, in_green[PD-1:0]} + {1'b0, in_green[2*PD-1:PD]};
    assign h_blue   = {1'b0, in_blue[PD-1:0]}  + {1'b0, in_blue[2*PD-1:PD]};
    assign lb_wdata = {h_blue, h_green, h_red};

    // Sum of four pixels plus 2, divided by 4. The total never exceeds
    // 4*(2^PD-1)+2, so PD+2 bits hold it without overflow.
    function automatic logic [PD-1:0] avg4(input logic [PD:0] upper, input logic [PD:0] lower);
        logic [PD+1:0] v;
        v = {1'b0, upper} + {1'b0, lower} + (PD+2)'(2);
        return v[PD+1:2];
    endfunction

    assign p = {avg4(lb_rdata[3*(PD+1)-1 -: PD+1], h_blue),
                avg4(lb_rdata[2*(PD+1)-1 -: PD+1], h_green),
                avg4(lb_rdata[PD:0],               h_red)};
`else
    // Only the top-left pixel of each block survives; right pixels are dropped.
    logic unused_right;

    assign lb_wdata     = {in_blue[PD-1:0], in_green[PD-1:0], in_red[PD-1:0]};
    assign p            = lb_rdata;
    assign unused_right = ^{in_red[2*PD-1:PD], in_green[2*PD-1:PD], in_blue[2*PD-1:PD]};
`endif

    // Line buffer: registered read address, so rdata always reflects the
    // entry for the current col. Only even rows write and only odd rows
    // read, which means the two ports never collide.
    assign lb_rdata = lb_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (!rst && acc && !row_odd) begin
            lb_mem[col] <= lb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            rd_addr   <= '0;
            row_odd   <= 1'b0;
            hold      <= '0;
            out_valid <= 1'b0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
        end else begin
            col     <= col_nxt;
            rd_addr <= col_nxt;
            if (acc && wrap) begin
                row_odd <= ~row_odd;
            end
            if (acc && row_odd && !col[0]) begin
                hold <= p;
            end
            // An odd col completes a pair of blocks: emit {right=p, left=hold}.
            if (acc && row_odd && col[0]) begin
                out_red   <= {p[PD-1:0],      hold[PD-1:0]};
                out_green <= {p[2*PD-1:PD],   hold[2*PD-1:PD]};
                out_blue  <= {p[3*PD-1:2*PD], hold[3*PD-1:2*PD]};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scale_down_2x_2ppc.sv
// tb/tb_scale_down_2x_2ppc.sv - self-checking bench for scale_down_2x_2ppc

module tb_scale_down_2x_2ppc;

    localparam int PD  = 8;
    localparam int W   = 8;
    localparam int AW  = 9;
    localparam int BPR = W / 2;
`ifdef SCALE_DOWN_2X_AVG_EN
    localparam bit AVG_MODEL = 1'b1;
`else
    localparam bit AVG_MODEL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [2*PD-1:0] in_red, in_green, in_blue;
    logic          in_valid;
    logic          in_ready;
    logic [2*PD-1:0] out_red, out_green, out_blue;
    logic          out_valid;
    logic          out_ready;

    scale_down_2x_2ppc #(.P_DEPTH(PD), .IN_FRAME_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int beats = 0;
    int ov_cycles = 0;
    bit count_ov  = 1'b0;
    bit full_rate = 1'b0;
    bit rows_done = 1'b0;

    logic [47:0] exp_q[$];
    logic [47:0] log_q[$];
    logic [7:0]  img [0:2][0:3][0:W-1];   // [channel r,g,b][row][pixel]

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference for one output pixel, from its 2x2 block (a b top, c d bottom).
    function automatic logic [7:0] model_pix(input int a, input int b, input int c, input int d);
        int avg;
        avg = (a + b + c + d + 2) / 4;
        return AVG_MODEL ? 8'(avg) : 8'(a);
    endfunction

    function automatic logic [7:0] block(input int ch, input int r, input int c);
        return model_pix(img[ch][r-1][c], img[ch][r-1][c+1], img[ch][r][c], img[ch][r][c+1]);
    endfunction

    task automatic build_expected(input int nrows);
        logic [15:0] ch_beat [0:2];
        for (int r = 1; r < nrows; r += 2) begin
            for (int j = 0; j < W / 4; j++) begin
                for (int ch = 0; ch < 3; ch++)
                    ch_beat[ch] = {block(ch, r, 4*j + 2), block(ch, r, 4*j)};
                exp_q.push_back({ch_beat[2], ch_beat[1], ch_beat[0]});
            end
        end
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < W; c++)
                    img[ch][r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic send_beat(input int r, input int cb);
        int n;
        in_red   = {img[0][r][2*cb+1], img[0][r][2*cb]};
        in_green = {img[1][r][2*cb+1], img[1][r][2*cb]};
        in_blue  = {img[2][r][2*cb+1], img[2][r][2*cb]};
        in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (full_rate) chk("full_rate_in_ready", 64'(in_ready), 64'd1);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                chk("in_ready_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rows(input int first, input int nrows);
        for (int r = first; r < first + nrows; r++)
            for (int cb = 0; cb < BPR; cb++)
                send_beat(r, cb);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic ready_pattern();
        int n;
        int cyc;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cyc = 0;
        while (!rows_done) begin
            @(posedge clk);
            #1;
            out_ready = (cyc % 3) != 0;
            cyc++;
        end
        out_ready = 1'b1;
    endtask

    // Output monitor: handshake rule, hold-while-stalled, and scoreboard.
    bit          stall_prev = 1'b0;
    bit          prev_ov    = 1'b0;
    logic [47:0] stall_data;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            prev_ov    = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stall_prev) begin
                chk("stall_valid_held", 64'(out_valid), 64'd1);
                chk("stall_data_held", 64'({out_blue, out_green, out_red}), 64'(stall_data));
            end
            if (out_valid && out_ready) begin
                beats++;
                log_q.push_back({out_blue, out_green, out_red});
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'({out_blue, out_green, out_red}), 64'd0 - 64'd1);
                end else begin
                    chk("out_beat", 64'({out_blue, out_green, out_red}), 64'(exp_q.pop_front()));
                end
            end
            if (count_ov) begin
                if (out_valid) ov_cycles++;
                chk("valid_alternates", 64'(out_valid && prev_ov), 64'd0);
            end
            prev_ov    = out_valid;
            stall_prev = out_valid && !out_ready;
            stall_data = {out_blue, out_green, out_red};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_red = '0; in_green = '0; in_blue = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_red",   64'(out_red),   64'd0);
        chk("reset_out_green", 64'(out_green), 64'd0);
        chk("reset_out_blue",  64'(out_blue),  64'd0);
        @(posedge clk);
        #1;

        // Model pins.
`ifdef SCALE_DOWN_2X_AVG_EN
        chk("model_round_1222", 64'(model_pix(1, 2, 2, 2)), 64'd2);
        chk("model_round_1112", 64'(model_pix(1, 1, 1, 2)), 64'd1);
        chk("model_max",        64'(model_pix(255, 255, 255, 255)), 64'd255);
`else
        chk("model_nn_pick", 64'(model_pix(32, 48, 64, 80)), 64'd32);
`endif

        // Directed two-row frame.
        for (int c = 0; c < W; c++) begin
`ifdef SCALE_DOWN_2X_AVG_EN
            img[0][0][c] = 8'd10;
            img[0][1][c] = 8'd14;
`else
            img[0][0][c] = (c % 2 == 0) ? 8'h20 : 8'h30;
            img[0][1][c] = (c % 2 == 0) ? 8'h40 : 8'h50;
`endif
            img[2][0][c] = 8'd100;
            img[2][1][c] = 8'd200;
        end
        img[1][0][0] = 1;   img[1][0][1] = 2;   img[1][1][0] = 2;   img[1][1][1] = 2;
        img[1][0][2] = 1;   img[1][0][3] = 1;   img[1][1][2] = 1;   img[1][1][3] = 2;
        img[1][0][4] = 255; img[1][0][5] = 255; img[1][1][4] = 255; img[1][1][5] = 255;
        img[1][0][6] = 0;   img[1][0][7] = 0;   img[1][1][6] = 0;   img[1][1][7] = 1;
        build_expected(2);
        log_q.delete();
        beats = 0;
        drive_rows(0, 2);
        drain();
        chk("directed_beats", 64'(beats), 64'd2);
        if (log_q.size() >= 2) begin
`ifdef SCALE_DOWN_2X_AVG_EN
            chk("dir_red0",   64'(log_q[0][15:0]),  64'h0C0C);
            chk("dir_red1",   64'(log_q[1][15:0]),  64'h0C0C);
            chk("dir_green0", 64'(log_q[0][31:16]), 64'h0102);
            chk("dir_green1", 64'(log_q[1][31:16]), 64'h00FF);
            chk("dir_blue0",  64'(log_q[0][47:32]), 64'h9696);
`else
            chk("dir_red0",   64'(log_q[0][15:0]),  64'h2020);
            chk("dir_red1",   64'(log_q[1][15:0]),  64'h2020);
            chk("dir_green0", 64'(log_q[0][31:16]), 64'h0101);
            chk("dir_green1", 64'(log_q[1][31:16]), 64'h00FF);
            chk("dir_blue0",  64'(log_q[0][47:32]), 64'h6464);
`endif
        end else begin
            chk("dir_log_size", 64'(log_q.size()), 64'd2);
        end

        // Full rate over four rows, no gaps at row boundaries.
        fill_random();
        build_expected(4);
        beats = 0; ov_cycles = 0;
        count_ov = 1'b1; full_rate = 1'b1;
        drive_rows(0, 4);
        full_rate = 1'b0;
        drain();
        count_ov = 1'b0;
        chk("full_rate_beats", 64'(beats), 64'd4);
        chk("full_rate_valid_cycles", 64'(ov_cycles), 64'd4);

        // Backpressure.
        fill_random();
        build_expected(4);
        beats = 0;
        rows_done = 1'b0;
        fork
            begin
                drive_rows(0, 4);
                rows_done = 1'b1;
            end
            ready_pattern();
        join
        out_ready = 1'b1;
        drain();
        chk("bp_beats", 64'(beats), 64'd4);

        // Reset in the middle of an odd row with a beat pending.
        fill_random();
        drive_rows(0, 1);
        out_ready = 1'b0;
        send_beat(1, 0);
        send_beat(1, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("post_reset_valid", 64'(out_valid), 64'd0);
        chk("post_reset_red",   64'(out_red),   64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fill_random();
        build_expected(2);
        beats = 0;
        drive_rows(0, 2);
        drain();
        chk("post_reset_beats", 64'(beats), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
